// File: rtl/layer_sequencer.sv
// Sequences NUM_LAYERS layers through one shared engine: drives config, pulses eng_start, waits for the eng_done rising edge.
// Latency per layer: SETUP + LAUNCH + NEXT (3 cycles) plus the WAIT duration; FINISH adds 1 cycle at the end of the pass.
// No backpressure: start is only sampled in IDLE; abort forces IDLE from any busy state; WAIT is bounded by TIMEOUT.
module layer_sequencer #(
    parameter int NUM_LAYERS = 3,
    parameter logic [8*(NUM_LAYERS+1)-1:0] SIZES = {8'd15, 8'd15, 8'd20, 8'd25},
    parameter int ADDR_W = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        layer_idx,
    output logic              eng_start,
    input  logic              eng_done,
    output logic [7:0]        eng_in_size,
    output logic [7:0]        eng_out_size,
    output logic [ADDR_W-1:0] w_base,
    output logic [ADDR_W-1:0] b_base,
    output logic              buf_sel,
    output logic [31:0]       cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LAUNCH,
        S_WAIT,
        S_NEXT,
        S_FINISH
    } state_t;

    localparam logic [31:0] TMO_LAST   = 32'(TIMEOUT - 1);
    localparam logic [3:0]  LAST_LAYER = 4'(NUM_LAYERS - 1);

    state_t      state;
    state_t      state_nxt;
    logic        eng_done_q;
    logic        rise;
    logic [31:0] tmo_cnt;
    logic        tmo_hit;
    logic        last_layer;
    logic        abort_hit;
    logic [3:0]  idx_plus1;
    logic [15:0] w_step;
    logic [7:0]  size_tab [16];

    // Size lookup table; entries past the last layer read as zero so any index is safe.
    for (genvar g = 0; g < 16; g++) begin : g_size
        if (g <= NUM_LAYERS) begin : g_used
            assign size_tab[g] = SIZES[g*8 +: 8];
        end else begin : g_unused
            assign size_tab[g] = 8'd0;
        end
    end

    assign idx_plus1    = layer_idx + 4'd1;
    assign eng_in_size  = size_tab[layer_idx];
    assign eng_out_size = size_tab[idx_plus1];
    assign w_step       = eng_in_size * eng_out_size;

    // Only a fresh low-to-high transition of eng_done counts as completion.
    assign rise       = eng_done & ~eng_done_q;
    assign tmo_hit    = (tmo_cnt == TMO_LAST);
    assign last_layer = (layer_idx == LAST_LAYER);
    assign abort_hit  = abort && (state != S_IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded outputs; abort overrides every busy transition.
    always_comb begin
        state_nxt = state;
        busy      = (state != S_IDLE);
        eng_start = (state == S_LAUNCH);
        done      = (state == S_FINISH);
        case (state)
            S_IDLE:   if (start) state_nxt = S_SETUP;
            S_SETUP:  state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT: begin
                if (rise) begin
                    state_nxt = S_NEXT;
                end else if (tmo_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_NEXT:   state_nxt = last_layer ? S_FINISH : S_SETUP;
            S_FINISH: state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (abort_hit) begin
            state_nxt = S_IDLE;
        end
    end

    // Layer configuration, timeout counter, sticky error and busy-cycle counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            eng_done_q <= 1'b0;
            tmo_cnt    <= '0;
            layer_idx  <= '0;
            w_base     <= '0;
            b_base     <= '0;
            buf_sel    <= 1'b0;
            cycles     <= '0;
            error      <= 1'b0;
        end else begin
            eng_done_q <= eng_done;
            if (state != S_IDLE && cycles != '1) begin
                cycles <= cycles + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        layer_idx <= '0;
                        w_base    <= '0;
                        b_base    <= '0;
                        buf_sel   <= 1'b0;
                        cycles    <= '0;
                        error     <= 1'b0;
                    end
                end
                S_LAUNCH: tmo_cnt <= '0;
                S_WAIT: begin
                    if (!abort && !rise) begin
                        if (tmo_hit) begin
                            error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt + 32'd1;
                        end
                    end
                end
                S_NEXT: begin
                    if (!abort && !last_layer) begin
                        w_base    <= w_base + ADDR_W'(w_step);
                        b_base    <= b_base + ADDR_W'(eng_out_size);
                        buf_sel   <= ~buf_sel;
                        layer_idx <= idx_plus1;
                    end
                end
                default: ;
            endcase
            if (abort_hit) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: default 3-layer instance plus a 1-layer instance with a short timeout.
// Engine models raise eng_done 10 cycles after eng_start and hold it until the next eng_start.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_layer_sequencer;

    typedef struct {
        logic [15:0] w;
        logic [15:0] b;
        logic [7:0]  in_sz;
        logic [7:0]  out_sz;
        logic        bsel;
        logic [3:0]  idx;
    } cfg_t;

    logic clk = 1'b0;
    logic rst_n, start, abort, done_force;
    logic busy, done, error, eng_start, eng_done, buf_sel;
    logic [3:0]  layer_idx;
    logic [7:0]  eng_in_size, eng_out_size;
    logic [15:0] w_base, b_base;
    logic [31:0] cycles;

    logic s_start, s_resp;
    logic s_busy, s_done, s_error, s_eng_start, s_eng_done, s_buf_sel;
    logic [3:0]  s_layer_idx;
    logic [7:0]  s_in_size, s_out_size;
    logic [15:0] s_w_base, s_b_base;
    logic [31:0] s_cycles;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    layer_sequencer u_main (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .layer_idx(layer_idx),
        .eng_start(eng_start), .eng_done(eng_done),
        .eng_in_size(eng_in_size), .eng_out_size(eng_out_size),
        .w_base(w_base), .b_base(b_base), .buf_sel(buf_sel), .cycles(cycles)
    );

    layer_sequencer #(
        .NUM_LAYERS(1), .SIZES({8'd4, 8'd8}), .ADDR_W(16), .TIMEOUT(16)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
        .busy(s_busy), .done(s_done), .error(s_error), .layer_idx(s_layer_idx),
        .eng_start(s_eng_start), .eng_done(s_eng_done),
        .eng_in_size(s_in_size), .eng_out_size(s_out_size),
        .w_base(s_w_base), .b_base(s_b_base), .buf_sel(s_buf_sel), .cycles(s_cycles)
    );

    // Engine models.
    int   ecnt = 0;
    logic edone = 1'b0;
    int   s_ecnt = 0;
    logic s_edone = 1'b0;

    always @(posedge clk) begin
        if (eng_start) begin
            ecnt  <= 10;
            edone <= 1'b0;
        end else if (ecnt != 0) begin
            ecnt <= ecnt - 1;
            if (ecnt == 1) edone <= 1'b1;
        end
    end
    assign eng_done = edone | done_force;

    always @(posedge clk) begin
        if (s_eng_start) begin
            s_ecnt  <= 10;
            s_edone <= 1'b0;
        end else if (s_ecnt != 0) begin
            s_ecnt <= s_ecnt - 1;
            if (s_ecnt == 1 && s_resp) s_edone <= 1'b1;
        end
    end
    assign s_eng_done = s_edone;

    // Monitors: count start/done pulses and record the configuration seen at each eng_start.
    cfg_t rec [32];
    int   n_start = 0;
    int   n_done = 0;
    cfg_t s_rec;
    int   s_n_start = 0;
    int   s_n_done = 0;

    always @(negedge clk) begin
        if (eng_start) begin
            rec[n_start % 32] <= '{w: w_base, b: b_base, in_sz: eng_in_size,
                                   out_sz: eng_out_size, bsel: buf_sel, idx: layer_idx};
            n_start <= n_start + 1;
        end
        if (done) n_done <= n_done + 1;
        if (s_eng_start) begin
            s_rec <= '{w: s_w_base, b: s_b_base, in_sz: s_in_size,
                       out_sz: s_out_size, bsel: s_buf_sel, idx: s_layer_idx};
            s_n_start <= s_n_start + 1;
        end
        if (s_done) s_n_done <= s_n_done + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp_v);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"},    32'(busy), 32'd0);
        chk({tag, "_done"},    32'(done), 32'd0);
        chk({tag, "_error"},   32'(error), 32'd0);
        chk({tag, "_estart"},  32'(eng_start), 32'd0);
        chk({tag, "_idx"},     32'(layer_idx), 32'd0);
        chk({tag, "_wbase"},   32'(w_base), 32'd0);
        chk({tag, "_bbase"},   32'(b_base), 32'd0);
        chk({tag, "_bufsel"},  32'(buf_sel), 32'd0);
        chk({tag, "_cycles"},  cycles, 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    cfg_t exp_tab [3];
    cfg_t r;
    int   base, dbase, sbase, sdbase, nb;
    logic got, prev;

    initial begin
        exp_tab[0] = '{w: 16'd0,   b: 16'd0,  in_sz: 8'd25, out_sz: 8'd20, bsel: 1'b0, idx: 4'd0};
        exp_tab[1] = '{w: 16'd500, b: 16'd20, in_sz: 8'd20, out_sz: 8'd15, bsel: 1'b1, idx: 4'd1};
        exp_tab[2] = '{w: 16'd800, b: 16'd35, in_sz: 8'd15, out_sz: 8'd15, bsel: 1'b0, idx: 4'd2};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; done_force = 1'b0;
        s_start = 1'b0; s_resp = 1'b1;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Full 3-layer pass, with a stray start pulse mid-pass.
        base = n_start; dbase = n_done;
        pulse_start();
        chk("main_busy_setup", 32'(busy), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            start = (i == 20);
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk("main_done_seen", 32'(got), 32'd1);
        chk("main_err", 32'(error), 32'd0);
        chk("main_idx_last", 32'(layer_idx), 32'd2);
        @(negedge clk);
        chk("main_busy_after", 32'(busy), 32'd0);
        chk("main_done_1cyc", 32'(done), 32'd0);
        chk("main_cycles", cycles, 32'd43);
        repeat (30) @(negedge clk);
        chk("main_n_start", 32'(n_start - base), 32'd3);
        chk("main_n_done", 32'(n_done - dbase), 32'd1);
        chk("main_cycles_hold", cycles, 32'd43);
        for (int k = 0; k < 3; k++) begin
            r = rec[(base + k) % 32];
            chk($sformatf("l%0d_w", k),    32'(r.w),      32'(exp_tab[k].w));
            chk($sformatf("l%0d_b", k),    32'(r.b),      32'(exp_tab[k].b));
            chk($sformatf("l%0d_in", k),   32'(r.in_sz),  32'(exp_tab[k].in_sz));
            chk($sformatf("l%0d_out", k),  32'(r.out_sz), 32'(exp_tab[k].out_sz));
            chk($sformatf("l%0d_buf", k),  32'(r.bsel),   32'(exp_tab[k].bsel));
            chk($sformatf("l%0d_idx", k),  32'(r.idx),    32'(exp_tab[k].idx));
        end

        // Stale done: eng_done held high from before start must not advance layer 0.
        done_force = 1'b1;
        repeat (2) @(negedge clk);
        base = n_start; dbase = n_done;
        pulse_start();
        repeat (7) @(negedge clk);
        chk("stale_idx", 32'(layer_idx), 32'd0);
        chk("stale_busy", 32'(busy), 32'd1);
        chk("stale_n_start", 32'(n_start - base), 32'd1);
        done_force = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("stale_done_seen", 32'(got), 32'd1);
        chk("stale_err", 32'(error), 32'd0);
        chk("stale_n_start_end", 32'(n_start - base), 32'd3);

        // Timeout on the small instance: engine never answers.
        s_resp = 1'b0;
        sbase = s_n_start; sdbase = s_n_done;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        nb = 0;
        for (int i = 0; i < 100 && s_busy; i++) begin
            nb++;
            @(negedge clk);
        end
        chk("tmo_busy_cycles", 32'(nb), 32'd18);
        chk("tmo_error", 32'(s_error), 32'd1);
        chk("tmo_cycles", s_cycles, 32'd18);
        chk("tmo_idx", 32'(s_layer_idx), 32'd0);
        repeat (5) @(negedge clk);
        chk("tmo_cycles_frozen", s_cycles, 32'd18);
        chk("tmo_error_sticky", 32'(s_error), 32'd1);
        chk("tmo_no_done", 32'(s_n_done - sdbase), 32'd0);
        chk("tmo_n_start", 32'(s_n_start - sbase), 32'd1);

        // Single-layer pass on the small instance.
        s_resp = 1'b1;
        sbase = s_n_start;
        s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        chk("one_err_cleared", 32'(s_error), 32'd0);
        for (int i = 0; i < 100 && !s_eng_done; i++) @(negedge clk);
        chk("one_eng_done_seen", 32'(s_eng_done), 32'd1);
        @(negedge clk);
        chk("one_done_early", 32'(s_done), 32'd0);
        @(negedge clk);
        chk("one_done_pulse", 32'(s_done), 32'd1);
        @(negedge clk);
        chk("one_busy_after", 32'(s_busy), 32'd0);
        chk("one_cycles", s_cycles, 32'd15);
        chk("one_n_start", 32'(s_n_start - sbase), 32'd1);
        chk("one_in_size", 32'(s_rec.in_sz), 32'd8);
        chk("one_out_size", 32'(s_rec.out_sz), 32'd4);
        chk("one_wbase", 32'(s_rec.w), 32'd0);

        // Abort in layer 1 WAIT on the same edge as the eng_done rise.
        base = n_start; dbase = n_done;
        pulse_start();
        prev = eng_done;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (layer_idx == 4'd1 && busy && eng_done && !prev) begin
                abort = 1'b1;
                got = 1'b1;
            end
            prev = eng_done;
        end
        chk("abort_hit_point", 32'(got), 32'd1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_error", 32'(error), 32'd1);
        repeat (30) @(negedge clk);
        chk("abort_n_start", 32'(n_start - base), 32'd2);
        chk("abort_no_done", 32'(n_done - dbase), 32'd0);
        chk("abort_error_sticky", 32'(error), 32'd1);

        // Restart clears error and starts over; then reset during layer 2 WAIT.
        pulse_start();
        chk("restart_error", 32'(error), 32'd0);
        chk("restart_idx", 32'(layer_idx), 32'd0);
        chk("restart_wbase", 32'(w_base), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (layer_idx == 4'd2 && busy && !eng_done) got = 1'b1;
        end
        chk("rst_reach_l2_wait", 32'(got), 32'd1);
        base = n_start; dbase = n_done;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_zero("midrst");
        repeat (30) @(negedge clk);
        chk("midrst_n_start", 32'(n_start - base), 32'd0);
        chk("midrst_no_done", 32'(n_done - dbase), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion, required finish before 100000 time units");
        $fatal(1);
    end

endmodule
